// File: rtl/upsize_stream_if.sv
// Stream bundle for upsize_stream: narrow input beats in, widened output beats out.
interface upsize_stream_if #(
  parameter int PARALLEL_IN = 4,
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 32
);
  // A beat moves on a side exactly in a cycle where its valid and ready are both high.
  // A producer holding valid may not withdraw it or change the beat until it is taken.
  logic [PARALLEL_IN*DIN_WIDTH-1:0]  din;
  logic                              din_valid;
  logic                              din_last;
  logic                              din_ready;
  logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout;
  logic                              dout_valid;
  logic                              dout_last;
  logic                              dout_ready;

  modport master (
    output din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );

  modport slave (
    input  din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/upsize_stream.sv
// Lossless widening of signed fixed-point lanes, behind an output register plus a
// one-entry skid buffer so full throughput holds under backpressure.
module upsize_stream #(
  parameter int PARALLEL_IN = 4,
  parameter int DIN_WIDTH   = 16,
  parameter int DIN_POINT   = 14,
  parameter int DOUT_WIDTH  = 32,
  parameter int DOUT_POINT  = 28
) (
  input  logic       clk,
  input  logic       rst,
  upsize_stream_if.slave bus,
  output logic [1:0] state_dbg
);
  localparam int SHIFT = DOUT_POINT - DIN_POINT;
  localparam int IW    = PARALLEL_IN * DIN_WIDTH;
  localparam int OW    = PARALLEL_IN * DOUT_WIDTH;

  if ((DOUT_POINT < DIN_POINT) || ((DOUT_WIDTH - DOUT_POINT) < (DIN_WIDTH - DIN_POINT)))
  begin : g_illegal_params
    $error("upsize_stream: output format cannot hold the input format losslessly");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  logic [OW-1:0]   conv;
  logic [OW-1:0]   or_data;
  logic            or_last;
  logic [OW-1:0]   sk_data;
  logic            sk_last;
  logic            din_ready_r;
  logic            dout_valid_r;
  logic            in_xfer;
  logic            out_xfer;

  // Sign-extend each lane to the wide format, then align the binary points.
  always_comb begin
    conv = '0;
    for (int i = 0; i < PARALLEL_IN; i++) begin
      logic signed [DIN_WIDTH-1:0]  lane;
      logic signed [DOUT_WIDTH-1:0] ext;
      lane = bus.din[i*DIN_WIDTH +: DIN_WIDTH];
      ext  = DOUT_WIDTH'(lane);
      conv[i*DOUT_WIDTH +: DOUT_WIDTH] = ext << SHIFT;
    end
  end

  assign in_xfer  = bus.din_valid & din_ready_r;
  assign out_xfer = dout_valid_r & bus.dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      or_data      <= '0;
      or_last      <= 1'b0;
      sk_data      <= '0;
      sk_last      <= 1'b0;
      din_ready_r  <= 1'b1;
      dout_valid_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            or_data      <= conv;
            or_last      <= bus.din_last;
            dout_valid_r <= 1'b1;
            state        <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            sk_data     <= conv;
            sk_last     <= bus.din_last;
            din_ready_r <= 1'b0;
            state       <= TWO;
          end else if (in_xfer && out_xfer) begin
            or_data <= conv;
            or_last <= bus.din_last;
          end else if (out_xfer) begin
            dout_valid_r <= 1'b0;
            state        <= EMPTY;
          end
        end
        TWO: begin
          // din_ready is low here, so only the drain of OR can happen.
          if (out_xfer) begin
            or_data     <= sk_data;
            or_last     <= sk_last;
            din_ready_r <= 1'b1;
            state       <= ONE;
          end
        end
        default: begin
          din_ready_r  <= 1'b1;
          dout_valid_r <= 1'b0;
          state        <= EMPTY;
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready_r;
  assign bus.dout       = or_data;
  assign bus.dout_last  = or_last;
  assign bus.dout_valid = dout_valid_r;
  assign state_dbg      = state;
endmodule

// File: tb/tb_upsize_stream.sv
// Bench for upsize_stream: directed lane values, streaming, backpressure, random
// handshakes against an expected-beat queue, mid-stream reset and a narrow-format instance.
module tb_upsize_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  upsize_stream_if #(.PARALLEL_IN(4), .DIN_WIDTH(16), .DOUT_WIDTH(32)) a ();
  upsize_stream_if #(.PARALLEL_IN(1), .DIN_WIDTH(8),  .DOUT_WIDTH(24)) b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  upsize_stream #(.PARALLEL_IN(4), .DIN_WIDTH(16), .DIN_POINT(14),
                  .DOUT_WIDTH(32), .DOUT_POINT(28))
    dut_a (.clk(clk), .rst(rst), .bus(a), .state_dbg(state_a));

  upsize_stream #(.PARALLEL_IN(1), .DIN_WIDTH(8), .DIN_POINT(7),
                  .DOUT_WIDTH(24), .DOUT_POINT(16))
    dut_b (.clk(clk), .rst(rst), .bus(b), .state_dbg(state_b));

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [128:0] exp_q[$];
  logic [128:0] e;
  logic         prev_hold = 1'b0;
  logic [127:0] prev_dout = '0;
  logic         prev_last = 1'b0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference widening for Q2.14 -> Q4.28: multiply by 2^14 in a wide signed integer.
  function automatic logic [127:0] ref_conv(input logic [63:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] s;
      longint v;
      s = d[i*16 +: 16];
      v = s;
      v = v * 16384;
      r[i*32 +: 32] = v[31:0];
    end
    return r;
  endfunction

  // Scoreboard and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_data", a.dout, prev_dout);
        check("hold_last", a.dout_last, prev_last);
        check("hold_valid", a.dout_valid, 1'b1);
      end
      if (a.dout_valid && a.dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", a.dout, e[127:0]);
          check("sb_last", a.dout_last, e[128]);
        end
        out_cnt++;
      end
      if (a.din_valid && a.din_ready) exp_q.push_back({a.din_last, ref_conv(a.din)});
      prev_hold = a.dout_valid && !a.dout_ready;
      prev_dout = a.dout;
      prev_last = a.dout_last;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int  n;
    logic acc;
    n = 0;
    a.din = d;
    a.din_last = l;
    a.din_valid = 1'b1;
    do begin
      acc = a.din_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 1'b0, 1'b1);
    a.din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  logic done_rand = 1'b0;
  int   base_cnt;

  initial begin
    a.din = '0; a.din_valid = 1'b0; a.din_last = 1'b0; a.dout_ready = 1'b0;
    b.din = '0; b.din_valid = 1'b0; b.din_last = 1'b0; b.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_valid", a.dout_valid, 1'b0);
    check("rst_ready", a.din_ready, 1'b1);
    check("rst_dout", a.dout, 128'h0);
    check("rst_last", a.dout_last, 1'b0);
    check("rst_state", state_a, 2'd0);

    // Directed lane values, one cycle after acceptance
    a.dout_ready = 1'b1;
    a.din = 64'h7FFF_8000_C000_4000; a.din_last = 1'b1; a.din_valid = 1'b1;
    @(posedge clk); #1;
    check("t1_dout", a.dout, 128'h1FFFC000_E0000000_F0000000_10000000);
    check("t1_valid", a.dout_valid, 1'b1);
    check("t1_last", a.dout_last, 1'b1);
    a.din = 64'h0000_0000_0000_0001; a.din_last = 1'b0;
    @(posedge clk); #1;
    check("t1_lsb", a.dout[31:0], 32'h0000_4000);
    a.din_valid = 1'b0;
    wait_drain();

    // 64 back-to-back beats
    base_cnt = out_cnt;
    for (int i = 0; i < 64; i++) begin
      a.din = {$urandom(), $urandom()};
      a.din_last = (i % 8 == 7);
      a.din_valid = 1'b1;
      @(posedge clk); #1;
      check("t2_din_ready", a.din_ready, 1'b1);
      check("t2_dout_valid", a.dout_valid, 1'b1);
    end
    a.din_valid = 1'b0;
    wait_drain();
    check("t2_count", out_cnt - base_cnt, 64);

    // Backpressure for 5 cycles mid-stream
    a.din = 64'h1111_2222_3333_4444; a.din_last = 1'b0; a.din_valid = 1'b1;
    @(posedge clk); #1;
    a.dout_ready = 1'b0;
    a.din = 64'h5555_6666_7777_8888; a.din_last = 1'b1;
    @(posedge clk); #1;
    check("t3_ready_drop", a.din_ready, 1'b0);
    check("t3_state_two", state_a, 2'd2);
    a.din = 64'h9999_AAAA_BBBB_CCCC; a.din_last = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("t3_ready_low", a.din_ready, 1'b0);
    end
    a.dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_ready_back", a.din_ready, 1'b1);
    @(posedge clk); #1;
    a.din_valid = 1'b0;
    wait_drain();

    // Random din_valid against alternating dout_ready
    base_cnt = out_cnt;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
          end
          send_beat({$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          a.dout_ready = ~a.dout_ready;
        end
      end
    join
    a.dout_ready = 1'b1;
    wait_drain();
    check("t4_count", out_cnt - base_cnt, 1000);

    // Reset while both registers are full
    a.dout_ready = 1'b0;
    send_beat(64'h0102_0304_0506_0708, 1'b0);
    send_beat(64'h1112_1314_1516_1718, 1'b1);
    check("t5_state_two", state_a, 2'd2);
    a.din = 64'h2122_2324_2526_2728; a.din_last = 1'b1; a.din_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a.din_valid = 1'b0;
    check("t5_valid", a.dout_valid, 1'b0);
    check("t5_ready", a.din_ready, 1'b1);
    check("t5_last", a.dout_last, 1'b0);
    check("t5_state", state_a, 2'd0);
    base_cnt = out_cnt;
    a.dout_ready = 1'b1;
    send_beat(64'h3132_3334_3536_3738, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t5_single", out_cnt - base_cnt, 1);
    check("t5_empty", exp_q.size(), 0);
    check("t5_idle", a.dout_valid, 1'b0);

    // Q1.7 -> Q8.16 instance
    b.dout_ready = 1'b1;
    b.din = 8'h80; b.din_last = 1'b1; b.din_valid = 1'b1;
    @(posedge clk); #1;
    check("t6_neg", b.dout, 24'hFF0000);
    check("t6_last", b.dout_last, 1'b1);
    b.din = 8'h7F; b.din_last = 1'b0;
    @(posedge clk); #1;
    check("t6_pos", b.dout, 24'h00FE00);
    b.din = 8'h01;
    @(posedge clk); #1;
    check("t6_lsb", b.dout, 24'h000200);
    b.din_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_idle", b.dout_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/upsize_stream.md
Name: upsize_stream

Overview:
- Inverse of the neuron-path downsize stage: widens PARALLEL_IN signed fixed-point lanes from a narrow format (DIN_WIDTH, DIN_POINT) to a wide accumulator format (DOUT_WIDTH, DOUT_POINT).
- Sits between narrow activation/weight storage and the neuron MAC accumulators.
- Uses a valid/ready stream with a registered output stage and a one-entry skid buffer, so full throughput holds under backpressure.
- The conversion is lossless.

Parameters:
PARALLEL_IN, 4, number of independent lanes
DIN_WIDTH, 16, input lane width (signed)
DIN_POINT, 14, input fractional bits
DOUT_WIDTH, 32, output lane width (signed)
DOUT_POINT, 28, output fractional bits
- Legal only if DOUT_POINT>=DIN_POINT and (DOUT_WIDTH-DOUT_POINT)>=(DIN_WIDTH-DIN_POINT).
- Illegal combinations abort elaboration via generate-time check.

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
din  in  PARALLEL_IN*DIN_WIDTH  packed lanes, lane0 at LSBs
din_valid  in  1  input beat valid
din_last  in  1  end-of-vector marker, travels with beat
din_ready  out  1  block can accept beat
dout  out  PARALLEL_IN*DOUT_WIDTH  widened lanes, lane0 at LSBs
dout_valid  out  1  output beat valid
dout_last  out  1  marker aligned with dout
dout_ready  in  1  downstream accepts beat

Behaviour:
- Per-lane arithmetic:
  - out = sign_extend(in) << (DOUT_POINT-DIN_POINT).
  - Fill the low shift bits with 0; sign-extend to DOUT_WIDTH.
  - Pure combinational function applied before the registers; no rounding, no saturation.
- Transfers: input on din_valid&din_ready; output on dout_valid&dout_ready.
- Storage: output register (OR) plus skid register (SK), each holding data and last.
- States (encoded by OR/SK occupancy):
  - EMPTY: OR empty, SK empty.
  - ONE: OR full, SK empty.
  - TWO: OR full, SK full.
- din_ready is registered and equals the state not being TWO.
- Transitions, with IN = input transfer and OUT = output transfer:
  - EMPTY + IN -> ONE; OR <= conv(din). Latency 1 cycle din->dout.
  - ONE + IN, no OUT -> TWO; SK <= conv(din).
  - ONE + IN + OUT -> ONE; OR <= conv(din).
  - ONE + OUT only -> EMPTY.
  - TWO + OUT -> ONE; OR <= SK. No IN is possible in TWO.
  - TWO, no OUT -> TWO, hold.
- Output stability: while dout_valid=1 and dout_ready=0, dout and dout_last must not change.
- Throughput: one beat per cycle whenever dout_ready is held high.
- Order: beats exit strictly in arrival order; none dropped or duplicated.
- din_valid while din_ready=0: ignored, no state change.
- Reset:
  - dout_valid=0, dout=0, dout_last=0, din_ready=1, state EMPTY.
  - Applies mid-stream: the in-flight beat in OR and SK is discarded.
  - While rst=1, din_valid is ignored.
- dout data when dout_valid=0: holds the last value; checkers must not rely on it.

Test Plan:
1. Q2.14 -> Q4.28 lane values, dout_ready=1:
   - din lanes {0x4000,0xC000,0x8000,0x7FFF} -> dout lanes {0x10000000,0xF0000000,0xE0000000,0x1FFFC000}, one cycle after acceptance.
   - lane0 = 0x0001 -> 0x00004000.
2. Streaming: 64 back-to-back beats with random data, dout_ready=1 -> 64 output beats in consecutive cycles, din_ready constant 1, dout_last matching input pattern.
3. Backpressure: dout_ready=0 for 5 cycles during a stream. Required: din_ready drops the cycle after the second beat is stored; dout held stable. On release, beats drain in order with no loss.
4. Alternating dout_ready (1,0,1,0...) with random din_valid, compared against a reference FIFO model:
   - zero mismatches over 1000 beats;
   - dout_valid&~dout_ready never shows dout changing.
5. Reset in state TWO:
   - rst=1 for 1 cycle -> next cycle dout_valid=0, din_ready=1, dout_last=0.
   - The next accepted beat appears alone, with no stale beat.
6. Parameter sweep DIN 8/Q1.7 -> DOUT 24/Q8.16: din 0x80 -> 0xFF0000; 0x7F -> 0x00FE00.
